hps_cmd_ingest: RTL and testbench

//  Avalon-MM byte-write slave between the HPS bridge and the sprite renderer. Assembles

---
 rtl/hps_cmd_ingest.sv | 196 +++++++++++++++++++
 tb/tb_hps_cmd_ingest.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hps_cmd_ingest.sv
// hps_cmd_ingest: Avalon-MM byte-write slave assembling render commands (to FIFO) and pixels (to image memory).
// Optional feature: define STATUS_READBACK_EN for hps_read/hps_readdata status register at address 15.
module hps_cmd_ingest #(
   parameter int unsigned CMD_BYTES = 6,
   parameter int unsigned PIX_BYTES = 3,
   parameter int unsigned MEM_AW    = 20,
   parameter int unsigned MEM_DEPTH = 2**MEM_AW,
   parameter logic [7:0]  OP_CLEAR  = 8'hFE
) (
   input  logic                   clk50,
   input  logic                   reset_n,
   input  logic [3:0]             hps_address,
   input  logic [7:0]             hps_writedata,
   input  logic                   hps_write,
   input  logic                   hps_chipselect,
`ifdef STATUS_READBACK_EN
   input  logic                   hps_read,
   output logic [7:0]             hps_readdata,
`endif
   output logic                   hps_waitrequest,
   input  logic                   q_full,
   output logic                   q_we,
   output logic [8*CMD_BYTES-1:0] q_din,
   output logic                   q_clear,
   output logic                   mem_we,
   output logic [MEM_AW-1:0]      mem_waddr,
   output logic [8*PIX_BYTES-1:0] mem_din
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUSH_WAIT,
      ST_CLEAR
   } state_e;

   localparam logic [3:0] A_CMD_END  = 4'(CMD_BYTES);
   localparam logic [3:0] A_CMD_LAST = 4'(CMD_BYTES - 1);
   localparam logic [3:0] A_PIX_BASE = 4'd8;
   localparam logic [3:0] A_PIX_END  = 4'(8 + PIX_BYTES);
   localparam logic [3:0] A_PIX_LAST = 4'(8 + PIX_BYTES - 1);
   localparam logic [3:0] A_WADDR_HI = 4'd12;
   localparam logic [3:0] A_WADDR_LO = 4'd14;
   localparam logic [3:0] A_CTRL     = 4'd15;
   localparam logic [MEM_AW-1:0] WADDR_LAST = MEM_AW'(MEM_DEPTH - 1);

   state_e state_q, state_d;

   logic [7:0]             cmd_q [CMD_BYTES];
   logic [7:0]             cmd_d [CMD_BYTES];
   logic [7:0]             pix_q [PIX_BYTES];
   logic [7:0]             pix_d [PIX_BYTES];
   logic [MEM_AW-1:0]      waddr_q, waddr_d;
   logic                   q_we_q, q_we_d;
   logic [8*CMD_BYTES-1:0] q_din_q, q_din_d;
   logic                   mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]      mem_waddr_q, mem_waddr_d;
   logic [8*PIX_BYTES-1:0] mem_din_q, mem_din_d;
   logic [8*CMD_BYTES-1:0] cmd_word;
   logic [8*PIX_BYTES-1:0] pix_word;

   logic access, cmd_hit, cmd_commit, pix_hit, pix_commit, addr_hit, clear_hit, push;
   int unsigned waddr_byte;

   always_comb begin
      access     = hps_write & hps_chipselect & ~hps_waitrequest;
      cmd_hit    = access && (hps_address < A_CMD_END);
      cmd_commit = access && (hps_address == A_CMD_LAST);
      pix_hit    = access && (hps_address >= A_PIX_BASE) && (hps_address < A_PIX_END);
      pix_commit = access && (hps_address == A_PIX_LAST);
      addr_hit   = access && (hps_address >= A_WADDR_HI) && (hps_address <= A_WADDR_LO);
      clear_hit  = access && (hps_address == A_CTRL) && (hps_writedata == OP_CLEAR);
      push       = ~q_full & (cmd_commit | (state_q == ST_PUSH_WAIT));
      waddr_byte = 32'(A_WADDR_LO - hps_address);
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_commit && q_full) state_d = ST_PUSH_WAIT;
            else if (clear_hit)       state_d = ST_CLEAR;
         end
         ST_PUSH_WAIT: if (!q_full) state_d = ST_IDLE;
         ST_CLEAR:     state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hps_waitrequest = (state_q != ST_IDLE);
      q_clear         = (state_q == ST_CLEAR);
   end

   always_comb begin
      cmd_d       = cmd_q;
      pix_d       = pix_q;
      waddr_d     = waddr_q;
      q_we_d      = 1'b0;
      q_din_d     = q_din_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr_q;
      mem_din_d   = mem_din_q;

      for (int unsigned i = 0; i < CMD_BYTES; i++)
         if (cmd_hit && (hps_address == 4'(i))) cmd_d[i] = hps_writedata;
      for (int unsigned i = 0; i < PIX_BYTES; i++)
         if (pix_hit && (hps_address == 4'(8 + i))) pix_d[i] = hps_writedata;

      // Word is built from the next-state staging so the committing byte is included.
      cmd_word = '0;
      for (int unsigned i = 0; i < CMD_BYTES; i++)
         cmd_word[8*(CMD_BYTES-1-i) +: 8] = cmd_d[i];
      pix_word = '0;
      for (int unsigned i = 0; i < PIX_BYTES; i++)
         pix_word[8*(PIX_BYTES-1-i) +: 8] = pix_d[i];

      if (push) begin
         q_we_d  = 1'b1;
         q_din_d = cmd_word;
      end

      if (clear_hit)
         for (int unsigned i = 0; i < CMD_BYTES; i++) cmd_d[i] = '0;

      if (pix_commit) begin
         mem_we_d    = 1'b1;
         mem_waddr_d = waddr_q;
         mem_din_d   = pix_word;
         waddr_d     = (waddr_q == WADDR_LAST) ? '0 : waddr_q + MEM_AW'(1);
      end

      if (addr_hit)
         for (int unsigned b = 0; b < MEM_AW; b++)
            if ((b / 8) == waddr_byte) waddr_d[b] = hps_writedata[b % 8];
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < CMD_BYTES; i++) cmd_q[i] <= '0;
         for (int unsigned i = 0; i < PIX_BYTES; i++) pix_q[i] <= '0;
         waddr_q     <= '0;
         q_we_q      <= 1'b0;
         q_din_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_din_q   <= '0;
      end else begin
         cmd_q       <= cmd_d;
         pix_q       <= pix_d;
         waddr_q     <= waddr_d;
         q_we_q      <= q_we_d;
         q_din_q     <= q_din_d;
         mem_we_q    <= mem_we_d;
         mem_waddr_q <= mem_waddr_d;
         mem_din_q   <= mem_din_d;
      end
   end

   assign q_we      = q_we_q;
   assign q_din     = q_din_q;
   assign mem_we    = mem_we_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_din   = mem_din_q;

`ifdef STATUS_READBACK_EN
   logic [4:0] push_count_q, push_count_d;
   logic [7:0] readdata_q, readdata_d;

   always_comb begin
      push_count_d = push_count_q;
      if (clear_hit)  push_count_d = '0;
      else if (push)  push_count_d = push_count_q + 5'd1;
      readdata_d = '0;
      if (hps_read && hps_chipselect && (hps_address == A_CTRL))
         readdata_d = {push_count_q, state_q == ST_CLEAR, q_full, state_q == ST_PUSH_WAIT};
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         push_count_q <= '0;
         readdata_q   <= '0;
      end else begin
         push_count_q <= push_count_d;
         readdata_q   <= readdata_d;
      end
   end

   assign hps_readdata = readdata_q;
`endif

endmodule

// File: tb/tb_hps_cmd_ingest.sv
// Scoreboard bench for hps_cmd_ingest: expected FIFO pushes and pixel writes queued at drive time, compared on output.
module tb_hps_cmd_ingest;

   localparam int unsigned CMD_BYTES = 6;
   localparam int unsigned PIX_BYTES = 3;
   localparam int unsigned MEM_AW    = 20;

   logic                   clk50 = 1'b0;
   logic                   reset_n;
   logic [3:0]             hps_address;
   logic [7:0]             hps_writedata;
   logic                   hps_write;
   logic                   hps_chipselect;
   logic                   hps_waitrequest;
   logic                   q_full;
   logic                   q_we;
   logic [8*CMD_BYTES-1:0] q_din;
   logic                   q_clear;
   logic                   mem_we;
   logic [MEM_AW-1:0]      mem_waddr;
   logic [8*PIX_BYTES-1:0] mem_din;
`ifdef STATUS_READBACK_EN
   logic                   hps_read;
   logic [7:0]             hps_readdata;
`endif

   always #5 clk50 = ~clk50;

   hps_cmd_ingest #(
      .CMD_BYTES(CMD_BYTES),
      .PIX_BYTES(PIX_BYTES),
      .MEM_AW   (MEM_AW),
      .OP_CLEAR (8'hFE)
   ) dut (
      .clk50          (clk50),
      .reset_n        (reset_n),
      .hps_address    (hps_address),
      .hps_writedata  (hps_writedata),
      .hps_write      (hps_write),
      .hps_chipselect (hps_chipselect),
`ifdef STATUS_READBACK_EN
      .hps_read       (hps_read),
      .hps_readdata   (hps_readdata),
`endif
      .hps_waitrequest(hps_waitrequest),
      .q_full         (q_full),
      .q_we           (q_we),
      .q_din          (q_din),
      .q_clear        (q_clear),
      .mem_we         (mem_we),
      .mem_waddr      (mem_waddr),
      .mem_din        (mem_din)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [8*CMD_BYTES-1:0] exp_cmd_q [$];
   logic [MEM_AW-1:0]      exp_addr_q [$];
   logic [8*PIX_BYTES-1:0] exp_pix_q [$];
   int unsigned cmd_pushed = 0, cmd_seen = 0, pix_pushed = 0, pix_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk50) begin
      if (q_we) begin
         check_eq("q_we_while_full", 64'(q_full), 64'd0);
         if (exp_cmd_q.size() == 0) check_eq("q_we_unexpected", 64'(q_we), 64'd0);
         else begin
            check_eq("q_din", 64'(q_din), 64'(exp_cmd_q.pop_front()));
            cmd_seen++;
         end
      end
      if (mem_we) begin
         if (exp_addr_q.size() == 0) check_eq("mem_we_unexpected", 64'(mem_we), 64'd0);
         else begin
            check_eq("mem_waddr", 64'(mem_waddr), 64'(exp_addr_q.pop_front()));
            check_eq("mem_din", 64'(mem_din), 64'(exp_pix_q.pop_front()));
            pix_seen++;
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 after the write was accepted.
   task automatic hps_wr(input logic [3:0] a, input logic [7:0] d);
      int unsigned n = 0;
      hps_address = a; hps_writedata = d; hps_write = 1'b1; hps_chipselect = 1'b1;
      while (hps_waitrequest && n < 100) begin
         @(posedge clk50); #2;
         n++;
      end
      if (n >= 100) check_eq("wr_timeout", 64'(hps_waitrequest), 64'd0);
      @(posedge clk50); #2;
      hps_write = 1'b0; hps_chipselect = 1'b0;
   endtask

   task automatic send_cmd(input logic [8*CMD_BYTES-1:0] w);
      for (int unsigned i = 0; i < CMD_BYTES; i++)
         hps_wr(4'(i), w[8*(CMD_BYTES-1-i) +: 8]);
   endtask

   task automatic expect_cmd(input logic [8*CMD_BYTES-1:0] w);
      exp_cmd_q.push_back(w);
      cmd_pushed++;
   endtask

   task automatic send_pix(input logic [23:0] p, input logic [MEM_AW-1:0] a);
      exp_addr_q.push_back(a);
      exp_pix_q.push_back(p);
      pix_pushed++;
      for (int unsigned i = 0; i < PIX_BYTES; i++)
         hps_wr(4'(8 + i), p[8*(PIX_BYTES-1-i) +: 8]);
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk50);
      #2;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_waitreq"}, 64'(hps_waitrequest), 64'd0);
      check_eq({tag, "_q_we"}, 64'(q_we), 64'd0);
      check_eq({tag, "_q_din"}, 64'(q_din), 64'd0);
      check_eq({tag, "_q_clear"}, 64'(q_clear), 64'd0);
      check_eq({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      check_eq({tag, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
      check_eq({tag, "_mem_din"}, 64'(mem_din), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; hps_address = '0; hps_writedata = '0;
      hps_write = 1'b0; hps_chipselect = 1'b0; q_full = 1'b0;
`ifdef STATUS_READBACK_EN
      hps_read = 1'b0;
`endif
      cycles(3);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      cycles(1);

      // Basic command push
      expect_cmd(48'h112233445566);
      send_cmd(48'h112233445566);
      cycles(2);

      // FIFO full: stall, then a single push once it drains
      q_full = 1'b1;
      expect_cmd(48'h112233445566);
      send_cmd(48'h112233445566);
      for (int unsigned i = 0; i < 5; i++) begin
         check_eq("stall_waitreq", 64'(hps_waitrequest), 64'd1);
         check_eq("stall_no_q_we", 64'(q_we), 64'd0);
         cycles(1);
      end
      q_full = 1'b0;
      cycles(1);
      check_eq("release_q_we", 64'(q_we), 64'd1);
      check_eq("release_waitreq", 64'(hps_waitrequest), 64'd0);
      cycles(1);
      check_eq("release_q_we_off", 64'(q_we), 64'd0);

      // Partial command: only last byte rewritten
      expect_cmd(48'h112233445577);
      hps_wr(4'd5, 8'h77);
      cycles(2);

      // Pixel writes with wrap at last address; bits above MEM_AW ignored
      hps_wr(4'd12, 8'hFF);
      hps_wr(4'd13, 8'hFF);
      hps_wr(4'd14, 8'hFF);
      send_pix(24'hAABBCC, 20'hFFFFF);
      send_pix(24'h010203, 20'h00000);
      exp_addr_q.push_back(20'h00001); exp_pix_q.push_back(24'h010204); pix_pushed++;
      hps_wr(4'd10, 8'h04);
      // Address write in the cycle the previous pixel's mem_we is high
      hps_wr(4'd14, 8'h10);
      send_pix(24'h0D0E0F, 20'h00010);
      cycles(2);

      // Clear: one-cycle pulse, staging zeroed
      hps_wr(4'd15, 8'hFE);
      check_eq("clear_pulse", 64'(q_clear), 64'd1);
      check_eq("clear_waitreq", 64'(hps_waitrequest), 64'd1);
      cycles(1);
      check_eq("clear_pulse_end", 64'(q_clear), 64'd0);
      check_eq("clear_waitreq_end", 64'(hps_waitrequest), 64'd0);
      hps_wr(4'd15, 8'h55);
      check_eq("other_opcode", 64'(q_clear), 64'd0);
      hps_wr(4'd7, 8'hEE);
      hps_wr(4'd0, 8'h42);
      expect_cmd(48'h420000000099);
      hps_wr(4'd5, 8'h99);
      cycles(2);

      // Reset during PUSH_WAIT drops the pending command
      q_full = 1'b1;
      hps_wr(4'd5, 8'h5A);
      check_eq("pre_reset_waitreq", 64'(hps_waitrequest), 64'd1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      cycles(2);
      reset_n = 1'b1;
      q_full = 1'b0;
      cycles(5);

      // Post-reset: staging and write address back to zero
      expect_cmd(48'h000000000001);
      hps_wr(4'd5, 8'h01);
      expect_cmd(48'h000000000002);
      hps_wr(4'd5, 8'h02);
      expect_cmd(48'h000000000003);
      hps_wr(4'd5, 8'h03);
      send_pix(24'h123456, 20'h00000);
      cycles(2);
`ifdef STATUS_READBACK_EN
      hps_address = 4'd15; hps_chipselect = 1'b1; hps_read = 1'b1;
      cycles(1);
      hps_read = 1'b0; hps_chipselect = 1'b0;
      check_eq("status_read", 64'(hps_readdata), 64'h18);
`endif

      cycles(3);
      check_eq("cmd_count", 64'(cmd_seen), 64'(cmd_pushed));
      check_eq("pix_count", 64'(pix_seen), 64'(pix_pushed));
      check_eq("cmd_queue_left", 64'(exp_cmd_q.size()), 64'd0);
      check_eq("pix_queue_left", 64'(exp_addr_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
